// File: rtl/encoder_modulo.sv
// Reduces an unsigned encoder count modulo MODULUS by restoring division,
// one quotient bit per cycle, producing the electrical angle and revolution index.
module encoder_modulo #(
  parameter int IN_WIDTH = 13,
  parameter int MODULUS  = 1170,
  parameter int QW       = IN_WIDTH - ($clog2(MODULUS + 1) - 1),
  localparam int RW      = $clog2(MODULUS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] encoder_input,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RW-1:0]       remainder,
  output logic [QW-1:0]       quotient,
  output logic                busy
);

  localparam int                SW       = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [IN_WIDTH:0] MOD_EXT  = (IN_WIDTH + 1)'(MODULUS);
  localparam logic [SW-1:0]     STEP_TOP = SW'(QW - 1);

  if (MODULUS < 2 || MODULUS >= (2 ** IN_WIDTH)) begin : g_param_check
    $error("encoder_modulo: MODULUS must lie in 2 .. 2**IN_WIDTH-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IN_WIDTH:0] work_q, work_d;
  logic [IN_WIDTH:0] trial;
  logic [QW-1:0]     quot_q, quot_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [SW-1:0]     step_q, step_d;

  // MODULUS<<step never exceeds IN_WIDTH bits because QW is sized from floor(log2(MODULUS)).
  assign trial = MOD_EXT << step_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = {1'b0, encoder_input};
          quot_d  = '0;
          step_d  = STEP_TOP;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (work_q >= trial) begin
          work_d         = work_q - trial;
          quot_d[step_q] = 1'b1;
        end
        if (step_q == '0) begin
          rem_d   = work_d[RW-1:0];
          state_d = S_DONE;
        end else begin
          step_d = step_q - SW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_CALC);
  assign out_valid = (state_q == S_DONE);
  assign remainder = rem_q;
  assign quotient  = quot_q;

endmodule

// File: tb/tb_encoder_modulo.sv
// Bench for encoder_modulo: directed literal cases, a cycle-level reference model
// on the default configuration, and two wider parameter sweeps.
module tb_encoder_modulo;

  localparam int IW  = 13;
  localparam int MOD = 1170;
  localparam int QW  = 3;
  localparam int RW  = 11;
  localparam int NSWEEP = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] encoder_input;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] remainder;
  logic [QW-1:0] quotient;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int sweep_done = 0;
  logic rst_s;

  always #5 clk = ~clk;

  encoder_modulo u_dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .encoder_input (encoder_input),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .remainder     (remainder),
    .quotient      (quotient),
    .busy          (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: cnt = -1 when waiting for a sample, else cycles elapsed since acceptance.
  int cnt = -1;
  int pend = 0;
  int m_rem = 0;
  int m_quo = 0;

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(cnt == -1));
    chk("busy", 32'(busy), 32'(cnt >= 0 && cnt < QW));
    chk("out_valid", 32'(out_valid), 32'(cnt == QW));
    if (cnt == -1 || cnt == QW) begin
      chk("remainder", 32'(remainder), m_rem);
      chk("quotient", 32'(quotient), m_quo);
    end
    if (reset) begin
      cnt <= -1;
      m_rem <= 0;
      m_quo <= 0;
    end else if (cnt == -1) begin
      if (in_valid) begin
        cnt <= 0;
        pend <= int'(encoder_input);
      end
    end else if (cnt < QW) begin
      cnt <= cnt + 1;
      if (cnt == QW - 1) begin
        m_rem <= pend % MOD;
        m_quo <= pend / MOD;
      end
    end else if (out_ready) begin
      cnt <= -1;
    end
  end

  task automatic run_one(input int val, input int er, input int eq, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    encoder_input = IW'(val);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, QW);
    chk({nm, "_rem"}, 32'(remainder), er);
    chk({nm, "_quo"}, 32'(quotient), eq);
    @(posedge clk); #1;
  endtask

  function automatic int pick_main();
    case ($urandom % 6)
      0: return 0;
      1: return MOD - 1;
      2: return MOD * int'($urandom_range(1, 7));
      3: return (1 << IW) - 1;
      default: return int'($urandom % (1 << IW));
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    encoder_input = '0;
    out_ready = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_s = 1'b0;
    reset = 1'b0;
    // first sample presented in the very cycle reset drops
    run_one(1169, 1169, 0, "m1169");
    run_one(1170, 0, 1, "m1170");
    run_one(2340, 0, 2, "m2340");
    run_one(8191, 1, 7, "m8191");
    run_one(7021, 1, 6, "m7021");
    run_one(0, 0, 0, "m0");

    // backpressure in DONE with an ignored in_valid pulse
    out_ready = 1'b0;
    in_valid = 1'b1;
    encoder_input = IW'(2340);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_rem", 32'(remainder), 0);
      chk("bp_quo", 32'(quotient), 2);
      in_valid = (i == 4);
      encoder_input = IW'(8191);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", 32'(in_ready), 1);
    chk("bp_hold_rem", 32'(remainder), 0);
    chk("bp_hold_quo", 32'(quotient), 2);

    // reset on second CALC cycle aborts the operation
    in_valid = 1'b1;
    encoder_input = IW'(5000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_idle", 32'(in_ready), 1);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_rem", 32'(remainder), 0);
    chk("abort_quo", 32'(quotient), 0);
    run_one(5000, 320, 4, "m5000");

    // random traffic checked by the negedge model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom % 300 == 0);
      out_ready = ($urandom % 4 != 0);
      in_valid = $urandom % 2;
      encoder_input = IW'(pick_main());
      @(posedge clk); #1;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    n = 0;
    while (sweep_done < 2 && n < 80000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweeps_finished", sweep_done, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  for (genvar k = 0; k < 2; k++) begin : g_sweep
    localparam int M   = (k == 0) ? 4096 : 3;
    localparam int QWK = 16 - ($clog2(M + 1) - 1);
    localparam int RWK = $clog2(M);

    logic           iv, ir, ov, ordy, bsy;
    logic [15:0]    din;
    logic [RWK-1:0] rem;
    logic [QWK-1:0] quo;

    encoder_modulo #(.IN_WIDTH(16), .MODULUS(M)) u_dut (
      .clk           (clk),
      .reset         (rst_s),
      .in_valid      (iv),
      .in_ready      (ir),
      .encoder_input (din),
      .out_valid     (ov),
      .out_ready     (ordy),
      .remainder     (rem),
      .quotient      (quo),
      .busy          (bsy)
    );

    function automatic logic [15:0] pick();
      case ($urandom % 5)
        0: return 16'(M * int'($urandom % (65536 / M)));
        1: return 16'(M - 1);
        2: return 16'hFFFF;
        default: return 16'($urandom);
      endcase
    endfunction

    initial begin
      int n;
      int v;
      bit hs;
      iv = 1'b0;
      din = '0;
      ordy = 1'b0;
      @(negedge rst_s);
      #1;
      for (int s = 0; s < NSWEEP; s++) begin
        v = int'(pick());
        n = 0;
        while (!ir && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        iv = 1'b1;
        din = 16'(v);
        @(posedge clk); #1;
        iv = 1'b0;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
          ordy = $urandom % 2;
          hs = ov && ordy;
          if (hs) begin
            chk($sformatf("sweep%0d_rem", M), 32'(rem), v % M);
            chk($sformatf("sweep%0d_quo", M), 32'(quo), v / M);
          end
          @(posedge clk); #1;
          n++;
        end
        if (!hs) chk($sformatf("sweep%0d_timeout", M), 32'(0), 1);
      end
      ordy = 1'b0;
      sweep_done++;
    end
  end

endmodule
